rcn_slave_buf: RTL and testbench
================================

Name: rcn_slave_buf

Overview:
- Responder end of the rcn ring bus. Removes request flits addressed to this slave from the ring and buffers them.
- Issues the buffered requests in order to a local register/memory backend over a cs/ack handshake.
- Collects write completions and read data, then injects response flits back into the ring at free slots.
- Up to DEPTH transactions may be in progress at once. Requests that arrive while the slave is full stay on the ring and are retried.

Parameters:
- DEPTH, 4, maximum transactions held between ring accept and response injection (power of two, 2..16).
- ADDR_MASK, 22'h3F0000, byte-address bits compared for decode.
- ADDR_BASE, 22'h010000, required value of (addr & ADDR_MASK).

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous assert, active-low
- rcn_in  input  67  ring input flit
- rcn_out  output  67  ring output flit, registered
- cs  output  1  backend command valid
- wr  output  1  command is write
- mask  output  4  byte enables
- addr  output  22  byte address, bits [1:0] always 0
- wdata  output  32  write data
- ack  input  1  backend accepts command this cycle
- rvalid  input  1  read data valid, returned in command order
- rdata  input  32  read data

Behaviour:
- Flit format, 67 bits, MSB first: {valid, pending, wr, id[5:0], seq[1:0], mask[3:0], addr[21:2], data[31:0]}.
  - Request flit: valid=1, pending=1.
  - Response flit: valid=1, pending=0.
  - Empty slot: valid=0.
- Reset (rst_n=0, asynchronous): rcn_out=0, cs=0, all pointers and counters 0, buffers empty. Nothing is held over across reset.
- Credit counter cnt (0..DEPTH):
  - +1 on request accept.
  - -1 on response injection.
  - Both in the same cycle: unchanged.
- Request hit: valid && pending && (({addr,2'b00} & ADDR_MASK) == ADDR_BASE).
- Accept: hit && cnt<DEPTH. The accepted flit is pushed into the request FIFO (DEPTH entries) with fields {wr,id,seq,mask,addr,data}.
- Hit while cnt==DEPTH: the flit passes through unchanged (retry on the next ring lap).
- Non-hit and response flits: pass through unchanged.
- rcn_out is registered, so every path has 1 cycle of latency in to out.
- Output slot selection, evaluated each cycle:
  1. Accepted slot or empty slot (valid=0): fill with the response-FIFO head if one is available, otherwise drive all-zero. Response injection pops the head.
  2. Otherwise: pass rcn_in through.
  - Accept and inject in the same cycle, in the same slot, is legal.
- Backend command:
  - cs=1 whenever the request FIFO is non-empty; fields are driven from the FIFO head.
  - The FIFO pops on cs&&ack; the next entry is presented the following cycle.
  - Fields must stay stable while cs=1 and ack=0.
- Completion tracking: a DEPTH-entry tag FIFO stores {wr,id,seq,mask,addr,wdata} for each acked command.
  - Write: on ack, the response {1,0,1,id,seq,mask,addr,wdata} is pushed directly to the response FIFO. It does not wait for rvalid.
  - Read: the tag waits for rvalid. The response {1,0,0,id,seq,mask,addr,rdata} is pushed on rvalid.
  - Response order must equal command order. Reads that are still pending block later write responses: write tags queue behind reads in the tag FIFO and complete when they reach the head.
  - A write tag at the head completes in the cycle it reaches the head, or in its ack cycle if the tag FIFO is empty.
  - rvalid only ever completes a read tag at the head.
- rvalid with no read outstanding is a backend error. It is ignored, and must be flagged by a bench assertion.
- Because of the credit counter, the request, tag and response FIFOs can never overflow. The counter is the only admission gate.
- All pointers wrap modulo DEPTH. Empty and full are derived from occupancy counters, not from pointer equality alone.
- Idle: with cnt==0, rcn_out is rcn_in delayed by one cycle (empty slots stay empty).

Test Plan:
- Single write: inject request id=3, seq=1, addr=22'h010040, mask=4'hF, data=32'hDEADBEEF with ack tied to 1.
  - Required: cs rises 1 cycle after the flit enters, with addr=22'h010040 and wdata=32'hDEADBEEF.
  - Required: the same slot leaves rcn_out as all-zero.
  - Required: the response (pending=0, wr=1, id=3, seq=1) appears in the first empty slot after the ack.
- Read with latency: read request to addr 22'h010100; rvalid arrives 5 cycles after ack with rdata=32'h12345678.
  - Required: response flit with data=32'h12345678, id and seq echoed, in the first empty slot after rvalid.
- Full / retry: ack held at 0, then 5 hit requests sent back-to-back.
  - Required: the first 4 are absorbed (cnt=4); the 5th passes through unchanged on rcn_out.
  - Required: after ack releases and 4 responses are injected, a resend of the 5th is accepted.
- Pass-through: a request to addr 22'h020000 (miss) and a foreign response flit.
  - Required: both emerge bit-identical 1 cycle later.
- Ordering: read A (rvalid delayed 8 cycles), then write B acked immediately.
  - Required: response A precedes response B on rcn_out.
- Simultaneous: an accepted request slot while a response is pending.
  - Required: that slot carries the response and cnt is unchanged.
- Reset mid-traffic: rst_n pulled low with 3 transactions outstanding.
  - Required: rcn_out=0 and cs=0 immediately; after release the block accepts new requests with cnt starting from 0.

Source files
------------

// File: rtl/rcn_slave_buf.sv
// Responder end of the rcn ring: takes requests for this slave off the ring, issues them
// to a local backend in order, and injects the responses back into free ring slots.
module rcn_slave_buf #(
    parameter int          DEPTH     = 4,
    parameter logic [21:0] ADDR_MASK = 22'h3F0000,
    parameter logic [21:0] ADDR_BASE = 22'h010000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [66:0] rcn_in,
    output logic [66:0] rcn_out,
    output logic        cs,
    output logic        wr,
    output logic [3:0]  mask,
    output logic [21:0] addr,
    output logic [31:0] wdata,
    input  logic        ack,
    input  logic        rvalid,
    input  logic [31:0] rdata
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int EW = 65;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [EW-1:0] req_mem [DEPTH];
    logic [EW-1:0] tag_mem [DEPTH];
    logic [EW-1:0] rsp_mem [DEPTH];

    logic [PW-1:0] req_wp, req_rp, tag_wp, tag_rp, rsp_wp, rsp_rp;
    logic [CW-1:0] req_cnt, tag_cnt, rsp_cnt, cnt;

    logic          hit, acc, free, inj, fire;
    logic          tag_push, tag_pop, rsp_push;
    logic [EW-1:0] req_head, tag_head, rsp_din;
    logic [66:0]   rcn_nxt;

    assign hit  = rcn_in[66] & rcn_in[65] &
                  (({rcn_in[51:32], 2'b00} & ADDR_MASK) == ADDR_BASE);
    assign acc  = hit && (cnt < FULL);
    assign free = acc || !rcn_in[66];
    assign inj  = free && (rsp_cnt != '0);

    assign req_head = req_mem[req_rp];
    assign tag_head = tag_mem[tag_rp];

    assign cs    = (req_cnt != '0);
    assign wr    = req_head[64];
    assign mask  = req_head[55:52];
    assign addr  = {req_head[51:32], 2'b00};
    assign wdata = req_head[31:0];
    assign fire  = cs & ack;

    // Completions leave strictly in command order; a write with nothing ahead skips the tag FIFO.
    always_comb begin
        rsp_push = 1'b0;
        tag_pop  = 1'b0;
        rsp_din  = tag_head;
        if (tag_cnt != '0) begin
            if (tag_head[64]) begin
                rsp_push = 1'b1;
                tag_pop  = 1'b1;
            end else if (rvalid) begin
                rsp_push = 1'b1;
                tag_pop  = 1'b1;
                rsp_din  = {tag_head[64:32], rdata};
            end
        end else if (fire && req_head[64]) begin
            rsp_push = 1'b1;
            rsp_din  = req_head;
        end
    end

    assign tag_push = fire && !((tag_cnt == '0) && req_head[64]);

    always_comb begin
        rcn_nxt = rcn_in;
        if (inj) begin
            rcn_nxt = {2'b10, rsp_mem[rsp_rp]};
        end else if (free) begin
            rcn_nxt = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (acc)      req_mem[req_wp] <= rcn_in[EW-1:0];
        if (tag_push) tag_mem[tag_wp] <= req_head;
        if (rsp_push) rsp_mem[rsp_wp] <= rsp_din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rcn_out <= '0;
            req_wp  <= '0;
            req_rp  <= '0;
            tag_wp  <= '0;
            tag_rp  <= '0;
            rsp_wp  <= '0;
            rsp_rp  <= '0;
            req_cnt <= '0;
            tag_cnt <= '0;
            rsp_cnt <= '0;
            cnt     <= '0;
        end else begin
            rcn_out <= rcn_nxt;
            if (acc)      req_wp <= req_wp + 1'b1;
            if (fire)     req_rp <= req_rp + 1'b1;
            if (tag_push) tag_wp <= tag_wp + 1'b1;
            if (tag_pop)  tag_rp <= tag_rp + 1'b1;
            if (rsp_push) rsp_wp <= rsp_wp + 1'b1;
            if (inj)      rsp_rp <= rsp_rp + 1'b1;
            req_cnt <= req_cnt + CW'(acc) - CW'(fire);
            tag_cnt <= tag_cnt + CW'(tag_push) - CW'(tag_pop);
            rsp_cnt <= rsp_cnt + CW'(rsp_push) - CW'(inj);
            cnt     <= cnt + CW'(acc) - CW'(inj);
        end
    end

endmodule

// File: tb/tb_rcn_slave_buf.sv
// Bench for rcn_slave_buf: directed ring/backend scenarios plus random traffic,
// all checked every cycle against a queue-based transaction model.
module tb_rcn_slave_buf;

    localparam int          DEPTH = 4;
    localparam logic [21:0] AMASK = 22'h3F0000;
    localparam logic [21:0] ABASE = 22'h010000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [66:0] rcn_in = '0;
    logic [66:0] rcn_out;
    logic        cs, wr;
    logic [3:0]  mask;
    logic [21:0] addr;
    logic [31:0] wdata;
    logic        ack = 1'b0;
    logic        rvalid = 1'b0;
    logic [31:0] rdata = '0;

    int checks = 0;
    int errors = 0;

    rcn_slave_buf #(.DEPTH(DEPTH), .ADDR_MASK(AMASK), .ADDR_BASE(ABASE)) dut (
        .clk(clk), .rst_n(rst_n), .rcn_in(rcn_in), .rcn_out(rcn_out),
        .cs(cs), .wr(wr), .mask(mask), .addr(addr), .wdata(wdata),
        .ack(ack), .rvalid(rvalid), .rdata(rdata)
    );

    always #5 clk = ~clk;

    // Transaction model: waiting requests, acked commands in order, ready responses.
    logic [64:0] m_req[$];
    logic [64:0] m_tag[$];
    logic [64:0] m_rsp[$];
    int          m_cnt = 0;
    logic [66:0] m_out = '0;

    typedef struct {
        string       name;
        logic [66:0] in;
        logic [66:0] exp;
    } vec_t;

    function automatic logic [66:0] mk(input logic w, input logic [5:0] id, input logic [1:0] sq,
                                       input logic [3:0] m, input logic [21:0] a,
                                       input logic [31:0] d, input logic p);
        return {1'b1, p, w, id, sq, m, a[21:2], d};
    endfunction

    function automatic logic [66:0] rnd_flit();
        logic [66:0] f;
        logic [21:0] a;
        int r;
        r = $urandom_range(0, 99);
        f = {3'($urandom), $urandom, $urandom};
        a = 22'($urandom);
        if (r < 35) begin
            f[66] = 1'b0;
        end else if (r < 70) begin
            a[21:16] = 6'h01;
            f = mk(1'($urandom), 6'($urandom), 2'($urandom), 4'($urandom), a, $urandom, 1'b1);
        end else if (r < 85) begin
            if (a[21:16] == 6'h01) a[21:16] = 6'h02;
            f = mk(1'($urandom), 6'($urandom), 2'($urandom), 4'($urandom), a, $urandom, 1'b1);
        end else begin
            f = mk(1'($urandom), 6'($urandom), 2'($urandom), 4'($urandom), a, $urandom, 1'b0);
        end
        return f;
    endfunction

    task automatic check(input string nm, input logic [66:0] act, input logic [66:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        m_req.delete();
        m_tag.delete();
        m_rsp.delete();
        m_cnt = 0;
        m_out = '0;
    endtask

    task automatic model_step();
        logic        hit, acc, free, inj, fire, tag_was_empty;
        logic [64:0] head;
        int          nrd;
        hit  = rcn_in[66] && rcn_in[65] && ((({rcn_in[51:32], 2'b00}) & AMASK) == ABASE);
        acc  = hit && (m_cnt < DEPTH);
        free = acc || !rcn_in[66];
        inj  = free && (m_rsp.size() > 0);
        if (inj) m_out = {2'b10, m_rsp.pop_front()};
        else if (free) m_out = '0;
        else m_out = rcn_in;
        fire = (m_req.size() > 0) && ack;
        nrd = 0;
        foreach (m_tag[i]) if (!m_tag[i][64]) nrd++;
        assert (!(rvalid && nrd == 0))
        else begin
            errors++;
            $display("FAIL backend_rvalid: rvalid=1 with %0d reads outstanding, required >0", nrd);
        end
        tag_was_empty = (m_tag.size() == 0);
        if (!tag_was_empty) begin
            if (m_tag[0][64]) begin
                m_rsp.push_back(m_tag.pop_front());
            end else if (rvalid) begin
                head = m_tag.pop_front();
                m_rsp.push_back({head[64:32], rdata});
            end
        end else if (fire && m_req[0][64]) begin
            m_rsp.push_back(m_req[0]);
        end
        if (fire) begin
            head = m_req.pop_front();
            if (!(tag_was_empty && head[64])) m_tag.push_back(head);
        end
        if (acc) m_req.push_back(rcn_in[64:0]);
        m_cnt = m_cnt + int'(acc) - int'(inj);
    endtask

    task automatic check_outputs();
        check("model_rcn_out", rcn_out, m_out);
        check("model_cs", 67'(cs), 67'(m_req.size() > 0));
        if (m_req.size() > 0)
            check("model_cmd", 67'({wr, mask, addr, wdata}),
                  67'({m_req[0][64], m_req[0][55:52], m_req[0][51:32], 2'b00, m_req[0][31:0]}));
    endtask

    task automatic tick();
        @(negedge clk);
        if (rst_n) begin
            check_outputs();
            model_step();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string nm, input int max, output logic [66:0] f);
        int i;
        i = 0;
        f = '0;
        while (!rcn_out[66] && i < max) begin
            tick();
            i++;
        end
        if (rcn_out[66]) f = rcn_out;
        else begin
            checks++;
            errors++;
            $display("FAIL %s: no response within %0d cycles, required one", nm, max);
        end
    endtask

    task automatic drain();
        rcn_in = '0;
        ack = 1'b1;
        repeat (16) tick();
        ack = 1'b0;
    endtask

    initial begin
        vec_t        tbl[6];
        logic [66:0] f, e, f1, f2, fa, fb, miss;
        logic [66:0] fr[5];
        logic        rd_pend;
        int          rd_tmr;

        tbl[0] = '{"pass_miss_req",  mk(1, 7, 0, 4'hF, 22'h020000, 32'hA5A5A5A5, 1), 67'h0};
        tbl[1] = '{"pass_foreign_rsp", mk(0, 9, 3, 4'h3, 22'h010080, 32'h0BADF00D, 0), 67'h0};
        tbl[2] = '{"empty_zero",     67'h0, 67'h0};
        tbl[3] = '{"empty_garbage",  mk(1, 2, 1, 4'h5, 22'h010010, 32'h13579BDF, 1), 67'h0};
        tbl[4] = '{"pass_miss_high", mk(0, 4, 2, 4'h1, 22'h3F0004, 32'h00000001, 1), 67'h0};
        tbl[5] = '{"pass_miss_bit",  mk(1, 8, 0, 4'hC, 22'h030000, 32'hFFFF0000, 1), 67'h0};
        tbl[3].in[66] = 1'b0;
        for (int i = 0; i < 6; i++) if (i != 2 && i != 3) tbl[i].exp = tbl[i].in;

        @(posedge clk);
        #1;
        check("reset_rcn_out", rcn_out, 67'h0);
        check("reset_cs", 67'(cs), 67'h0);
        rst_n = 1'b1;
        tick();

        // Single write with ack tied high
        ack = 1'b1;
        f1 = mk(1, 6'd3, 2'd1, 4'hF, 22'h010040, 32'hDEADBEEF, 1);
        rcn_in = f1;
        check("wr_cs_before", 67'(cs), 67'h0);
        tick();
        rcn_in = '0;
        check("wr_cs", 67'(cs), 67'h1);
        check("wr_addr", 67'(addr), 67'(22'h010040));
        check("wr_wdata", 67'(wdata), 67'(32'hDEADBEEF));
        check("wr_slot_zero", rcn_out, 67'h0);
        tick();
        wait_valid("wr_rsp_wait", 10, f);
        e = f1;
        e[65] = 1'b0;
        check("wr_rsp", f, e);
        tick();

        // Read with 5-cycle backend latency
        f2 = mk(0, 6'd5, 2'd2, 4'hF, 22'h010100, 32'h0, 1);
        rcn_in = f2;
        tick();
        rcn_in = '0;
        check("rd_cs_wr", 67'({cs, wr}), 67'b10);
        tick();
        ack = 1'b0;
        repeat (4) tick();
        rvalid = 1'b1;
        rdata = 32'h12345678;
        tick();
        rvalid = 1'b0;
        wait_valid("rd_rsp_wait", 10, f);
        check("rd_rsp", f, {2'b10, f2[64:32], 32'h12345678});
        tick();

        // Full: five hits with ack held low
        ack = 1'b0;
        for (int i = 0; i < 5; i++) begin
            fr[i] = mk(1, 6'(10 + i), 2'(i), 4'h3, 22'h010200 + 22'(4 * i), $urandom, 1);
            rcn_in = fr[i];
            tick();
            if (i < 4) check("full_absorb", rcn_out, 67'h0);
            else check("full_retry_pass", rcn_out, fr[4]);
        end
        rcn_in = '0;
        ack = 1'b1;
        tick();
        for (int k = 0; k < 4; k++) begin
            wait_valid("full_rsp_wait", 20, f);
            check("full_rsp_id", 67'(f[63:58]), 67'(10 + k));
            tick();
        end
        rcn_in = fr[4];
        tick();
        rcn_in = '0;
        check("retry_accept", rcn_out, 67'h0);
        wait_valid("retry_rsp_wait", 20, f);
        check("retry_rsp_id", 67'(f[63:58]), 67'd14);
        drain();

        // Pass-through table
        for (int i = 0; i < 6; i++) begin
            rcn_in = tbl[i].in;
            tick();
            check(tbl[i].name, rcn_out, tbl[i].exp);
        end
        rcn_in = '0;
        tick();

        // Ordering: slow read A then write B
        ack = 1'b1;
        fa = mk(0, 6'd20, 2'd0, 4'hF, 22'h010300, 32'h0, 1);
        fb = mk(1, 6'd21, 2'd1, 4'hF, 22'h010304, 32'hCAFEF00D, 1);
        rcn_in = fa;
        tick();
        rcn_in = fb;
        tick();
        rcn_in = '0;
        repeat (7) tick();
        rvalid = 1'b1;
        rdata = 32'h55AA55AA;
        tick();
        rvalid = 1'b0;
        wait_valid("ord_first_wait", 10, f);
        check("ord_first", 67'({f[64], f[63:58], f[31:0]}), 67'({1'b0, 6'd20, 32'h55AA55AA}));
        tick();
        wait_valid("ord_second_wait", 10, f);
        check("ord_second", 67'({f[64], f[63:58]}), 67'({1'b1, 6'd21}));
        drain();

        // Accept and inject in the same slot
        ack = 1'b1;
        miss = mk(1, 6'd1, 2'd0, 4'hF, 22'h020000, 32'h11111111, 1);
        f1 = mk(1, 6'd30, 2'd2, 4'hF, 22'h010400, 32'h30303030, 1);
        f2 = mk(1, 6'd31, 2'd3, 4'hF, 22'h010404, 32'h31313131, 1);
        rcn_in = f1;
        tick();
        rcn_in = miss;
        repeat (3) tick();
        rcn_in = f2;
        tick();
        rcn_in = '0;
        e = f1;
        e[65] = 1'b0;
        check("simul_inject", rcn_out, e);
        tick();
        wait_valid("simul_second_wait", 10, f);
        check("simul_second_id", 67'(f[63:58]), 67'd31);
        drain();

        // Reset with three transactions outstanding
        ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rcn_in = mk(1, 6'(40 + i), 2'd0, 4'hF, 22'h010500 + 22'(4 * i), $urandom, 1);
            tick();
        end
        rcn_in = miss;
        tick();
        rcn_in = '0;
        rst_n = 1'b0;
        #1;
        check("rst_rcn_out", rcn_out, 67'h0);
        check("rst_cs", 67'(cs), 67'h0);
        model_reset();
        repeat (2) tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rcn_in = mk(1, 6'(50 + i), 2'd1, 4'hF, 22'h010600 + 22'(4 * i), $urandom, 1);
            tick();
            check("post_rst_accept", rcn_out, 67'h0);
        end
        rcn_in = '0;
        ack = 1'b1;
        tick();
        wait_valid("post_rst_rsp_wait", 20, f);
        check("post_rst_rsp_id", 67'(f[63:58]), 67'd50);
        drain();

        // Random traffic; the backend keeps at most one read in flight
        rd_pend = 1'b0;
        rd_tmr = 0;
        for (int n = 0; n < 3000; n++) begin
            if (rvalid) begin
                rvalid = 1'b0;
                rd_pend = 1'b0;
            end
            if (rd_pend) begin
                rd_tmr--;
                if (rd_tmr == 0) begin
                    rvalid = 1'b1;
                    rdata = $urandom;
                end
            end
            ack = ($urandom_range(0, 2) != 0);
            if (cs && !wr && rd_pend) ack = 1'b0;
            if (ack && cs && !wr) begin
                rd_pend = 1'b1;
                rd_tmr = $urandom_range(5, 9);
            end
            rcn_in = rnd_flit();
            tick();
        end
        rvalid = 1'b0;
        rcn_in = '0;
        ack = 1'b0;
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
